stream_arbiter: RTL and testbench

STREAM_ARBITER -- requirements
Module: stream_arbiter

---
 rtl/stream_arbiter.sv | 162 ++++++++++++++++
 tb/tb_stream_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// Round-robin arbiter merging NUM_SRC snoop sources onto one AXI-Stream output.
// Beats pass through a 2-entry FIFO whose head register drives the stream directly.
//
// state | meaning
// IDLE  | no owner; next valid source is chosen round-robin starting at rr_ptr
// GRANT | gnt owns the stream until its src_valid and src_in_progress are both low
module stream_arbiter #(
    parameter int          DATA_WIDTH      = 128,
    parameter int          NUM_SRC         = 5,
    parameter int          IDX_WIDTH       = 3,
    // Reset value of beat_count; nonzero only to exercise saturation.
    parameter logic [31:0] BEAT_COUNT_INIT = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC-1:0]            src_in_progress,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [IDX_WIDTH-1:0]          m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [31:0]                   beat_count
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam int ENTRY_W = IDX_WIDTH + DATA_WIDTH;

    logic [0:0]            state;
    logic [IDX_WIDTH-1:0]  gnt;
    logic [IDX_WIDTH-1:0]  rr_ptr;
    logic [IDX_WIDTH-1:0]  next_gnt;
    logic [IDX_WIDTH-1:0]  ptr_after_gnt;
    logic                  any_valid;

    logic                  gnt_valid;
    logic                  gnt_in_progress;
    logic [DATA_WIDTH-1:0] gnt_data;

    logic [ENTRY_W-1:0]    fifo_head;
    logic [ENTRY_W-1:0]    fifo_tail;
    logic [ENTRY_W-1:0]    push_entry;
    logic [1:0]            fifo_count;
    logic                  push;
    logic                  pop;

    logic [31:0]           beat_count_q;

    // Lowest rotation offset from rr_ptr wins: scanning offsets downward lets it assign last.
    always_comb begin
        next_gnt  = '0;
        any_valid = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (((int'(rr_ptr) + k) % NUM_SRC) == i && src_valid[i]) begin
                    next_gnt  = IDX_WIDTH'(i);
                    any_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_valid       = 1'b0;
        gnt_in_progress = 1'b0;
        gnt_data        = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt == IDX_WIDTH'(i)) begin
                gnt_valid       = src_valid[i];
                gnt_in_progress = src_in_progress[i];
                gnt_data        = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (state == GRANT) && (gnt == IDX_WIDTH'(i)) && (fifo_count < 2'd2);
        end
    end

    assign ptr_after_gnt = (gnt == IDX_WIDTH'(NUM_SRC - 1)) ? '0 : gnt + IDX_WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt   <= next_gnt;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!gnt_valid && !gnt_in_progress) begin
                        state  <= IDLE;
                        rr_ptr <= ptr_after_gnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // src_ready is only raised below two entries, so a push never meets a full FIFO.
    assign push       = |(src_ready & src_valid);
    assign pop        = m_axis_tvalid && m_axis_tready;
    assign push_entry = {gnt, gnt_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_head  <= '0;
            fifo_tail  <= '0;
            fifo_count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        fifo_head <= push_entry;
                    end else begin
                        fifo_tail <= push_entry;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    fifo_head  <= fifo_tail;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        fifo_head <= push_entry;
                    end else begin
                        fifo_head <= fifo_tail;
                        fifo_tail <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid                 = (fifo_count != 2'd0);
    assign {m_axis_tuser, m_axis_tdata}  = fifo_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count_q <= BEAT_COUNT_INIT;
        end else if (pop && (beat_count_q != 32'hFFFF_FFFF)) begin
            beat_count_q <= beat_count_q + 32'd1;
        end
    end

    assign beat_count = beat_count_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Randomized scoreboard bench for stream_arbiter: a transaction-level round-robin
// model predicts the output beat order; a monitor pops and compares every stream beat.
module tb_stream_arbiter;

    localparam int          DW       = 128;
    localparam int          NS       = 5;
    localparam int          IW       = 3;
    localparam logic [31:0] SAT_INIT = 32'hFFFF_FFFE;
    localparam int          DRAIN_MAX = 1500;

    logic            clk = 1'b0;
    logic            reset;
    logic [NS-1:0]   src_valid;
    logic [NS-1:0]   src_in_progress;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]   src_ready;
    logic [DW-1:0]   m_axis_tdata;
    logic [IW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [31:0]     beat_count;

    logic [NS-1:0]   sat_src_ready;
    logic [DW-1:0]   sat_tdata;
    logic [IW-1:0]   sat_tuser;
    logic            sat_tvalid;
    logic [31:0]     sat_beat_count;

    always #5 clk = ~clk;

    stream_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .IDX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_in_progress(src_in_progress), .src_data(src_data),
        .src_ready(src_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .beat_count(beat_count)
    );

    // Identical twin with the beat counter preloaded near saturation.
    stream_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .IDX_WIDTH(IW),
                     .BEAT_COUNT_INIT(SAT_INIT)) dut_sat (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_in_progress(src_in_progress), .src_data(src_data),
        .src_ready(sat_src_ready),
        .m_axis_tdata(sat_tdata), .m_axis_tuser(sat_tuser),
        .m_axis_tvalid(sat_tvalid), .m_axis_tready(m_axis_tready),
        .beat_count(sat_beat_count)
    );

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } out_t;

    beat_t     src_q     [NS][$];
    beat_t     stage_q   [NS][$];
    int        stage_len [NS][$];
    out_t      exp_q[$];

    int        gap    [NS];
    bit        in_txn [NS];
    logic [NS-1:0] hs_prev = '0;
    beat_t     drv_b;

    int        checks       = 0;
    int        failures     = 0;
    int        tready_pct   = 100;
    int        bubble_pct   = 0;
    int        cap_cnt      = 0;
    int        model_ptr    = 0;
    int        beats_loaded = 0;

    logic [DW-1:0] d_first;
    beat_t         tmp_b;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic add_txn(input int s, input int len);
        beat_t b;
        stage_len[s].push_back(len);
        for (int j = 0; j < len; j++) begin
            b.last = (j == len - 1);
            b.data = {$urandom, $urandom, $urandom, $urandom};
            stage_q[s].push_back(b);
        end
    endtask

    // Whole transactions in round-robin order over sources that still have work.
    task automatic commit_phase();
        int    pos [NS];
        int    len;
        int    s;
        bit    found;
        beat_t b;
        out_t  e;
        @(posedge clk);
        #2;
        for (int i = 0; i < NS; i++) pos[i] = 0;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 0; k < NS && !found; k++) begin
                s = (model_ptr + k) % NS;
                if (stage_len[s].size() > 0) begin
                    len = stage_len[s].pop_front();
                    for (int j = 0; j < len; j++) begin
                        b = stage_q[s][pos[s]];
                        pos[s]++;
                        e.idx  = IW'(s);
                        e.data = b.data;
                        exp_q.push_back(e);
                    end
                    beats_loaded += len;
                    model_ptr = (s + 1) % NS;
                    found = 1'b1;
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            while (stage_q[i].size() > 0) src_q[i].push_back(stage_q[i].pop_front());
        end
        cap_cnt = 0;
    endtask

    function automatic bit sources_busy();
        bit busy = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0 || gap[i] > 0) busy = 1'b1;
        end
        return busy;
    endfunction

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || sources_busy()) && n < DRAIN_MAX) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= DRAIN_MAX) begin
            failures++;
            $display("FAIL %s_drain: %0d beats outstanding after %0d cycles, required 0",
                     name, exp_q.size(), n);
        end
        repeat (4) @(negedge clk);
        check({name, "_beat_count"}, beat_count, beats_loaded);
        check({name, "_sat_count"}, sat_beat_count,
              (beats_loaded > 0) ? 32'hFFFF_FFFF : SAT_INIT);
    endtask

    task automatic clear_bench_state();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            stage_q[i].delete();
            stage_len[i].delete();
            gap[i]    = 0;
            in_txn[i] = 1'b0;
        end
        exp_q.delete();
        hs_prev      = '0;
        model_ptr    = 0;
        beats_loaded = 0;
    endtask

    // Source driver: one beat queue per source, a short idle gap after each transaction.
    initial begin
        src_valid       = '0;
        src_in_progress = '0;
        src_data        = '0;
        m_axis_tready   = 1'b0;
        forever begin
            @(negedge clk);
            for (int s = 0; s < NS; s++) begin
                if (hs_prev[s] && src_q[s].size() > 0) begin
                    drv_b = src_q[s].pop_front();
                    if (drv_b.last) begin
                        gap[s]    = 1 + $urandom_range(1);
                        in_txn[s] = 1'b0;
                    end else begin
                        in_txn[s] = 1'b1;
                    end
                end
                if (gap[s] > 0) begin
                    src_valid[s]       = 1'b0;
                    src_in_progress[s] = 1'b0;
                    gap[s]--;
                end else if (src_q[s].size() == 0) begin
                    src_valid[s]       = 1'b0;
                    src_in_progress[s] = 1'b0;
                end else begin
                    drv_b = src_q[s][0];
                    src_in_progress[s]     = in_txn[s] || !drv_b.last;
                    src_valid[s]           = !(in_txn[s] && ($urandom_range(99) < bubble_pct));
                    src_data[s*DW +: DW]   = drv_b.data;
                end
            end
            m_axis_tready = ($urandom_range(99) < tready_pct);
            #4;
            hs_prev = src_valid & src_ready;
            cap_cnt += $countones(hs_prev);
        end
    end

    // Monitor: compares every delivered beat with the scoreboard head.
    initial begin
        bit            prev_stall;
        logic [IW+DW-1:0] prev_beat;
        out_t          e;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_tvalid", m_axis_tvalid, 1'b1);
                    check("hold_beat", {m_axis_tuser, m_axis_tdata}, prev_beat);
                end
                check("ready_onehot", ($countones(src_ready) <= 1), 1'b1);
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got tuser=%0d tdata=%h, required no beat",
                                 m_axis_tuser, m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_tuser", m_axis_tuser, e.idx);
                        check("beat_tdata", m_axis_tdata, e.data);
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat  = {m_axis_tuser, m_axis_tdata};
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_tvalid", m_axis_tvalid, 1'b0);
        check("reset_src_ready", src_ready, '0);
        check("reset_tdata", m_axis_tdata, '0);
        check("reset_tuser", m_axis_tuser, '0);
        check("reset_beat_count", beat_count, 32'd0);
        check("reset_sat_count", sat_beat_count, SAT_INIT);
        reset = 1'b0;

        // Single beat from source 0: one IDLE cycle, then ready, then stream valid.
        tready_pct = 100;
        bubble_pct = 0;
        add_txn(0, 1);
        tmp_b   = stage_q[0][0];
        d_first = tmp_b.data;
        commit_phase();
        @(negedge clk); #4;
        check("single_ready_idle", src_ready, 5'b00000);
        check("single_tvalid_idle", m_axis_tvalid, 1'b0);
        @(negedge clk); #4;
        check("single_ready_grant", src_ready, 5'b00001);
        @(negedge clk); #4;
        check("single_tvalid", m_axis_tvalid, 1'b1);
        check("single_tuser", m_axis_tuser, 3'd0);
        check("single_tdata", m_axis_tdata, d_first);
        @(negedge clk); #4;
        check("single_beat_count", beat_count, 32'd1);
        wait_drain("single");

        // Burst lock: source 2 keeps the grant for its 4 beats while source 0 waits.
        add_txn(2, 4);
        add_txn(0, 1);
        commit_phase();
        wait_drain("burst_lock");

        // Backpressure: only two beats fit before src_ready drops.
        tready_pct = 0;
        add_txn(3, 4);
        tmp_b   = stage_q[3][0];
        d_first = tmp_b.data;
        commit_phase();
        repeat (10) @(negedge clk);
        #4;
        check("bp_captures", cap_cnt, 2);
        check("bp_src_ready", src_ready, 5'b00000);
        check("bp_tvalid", m_axis_tvalid, 1'b1);
        check("bp_tuser", m_axis_tuser, 3'd3);
        check("bp_tdata", m_axis_tdata, d_first);
        tready_pct = 100;
        wait_drain("backpressure");

        // Round robin between sources 0 and 2 (pointer now past source 3).
        add_txn(0, 1);
        add_txn(0, 1);
        add_txn(2, 1);
        add_txn(2, 1);
        commit_phase();
        wait_drain("round_robin");

        // Reset with a full FIFO mid-burst.
        tready_pct = 0;
        add_txn(1, 4);
        commit_phase();
        repeat (8) @(negedge clk);
        #4;
        check("rst_pre_tvalid", m_axis_tvalid, 1'b1);
        check("rst_pre_captures", cap_cnt, 2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        clear_bench_state();
        #1;
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_src_ready", src_ready, 5'b00000);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_tuser", m_axis_tuser, '0);
        check("rst_beat_count", beat_count, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        tready_pct = 100;
        add_txn(3, 1);
        add_txn(1, 1);
        commit_phase();
        wait_drain("post_reset");

        // Randomized phases with random backpressure and in-burst bubbles.
        for (int p = 0; p < 40; p++) begin
            tready_pct = 30 + $urandom_range(70);
            bubble_pct = $urandom_range(40);
            for (int s = 0; s < NS; s++) begin
                int ntx;
                ntx = $urandom_range(2);
                for (int t = 0; t < ntx; t++) add_txn(s, 1 + $urandom_range(3));
            end
            commit_phase();
            wait_drain("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
